// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - fetch, data and RAM-side signal bundle for memory_arbiter
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  // Arbiter side: takes requests and RAM status, drives responses and RAM strobes.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  // Environment side: CPU requesters plus the RAM model.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin fetch/data arbiter in front of a single-port RAM with access timeout
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, ABORT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam logic       SIDE_D     = 1'b0;
  localparam logic       SIDE_I     = 1'b1;
  // Counter value seen in the last access cycle allowed before giving up.
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_grant;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        ren_q;
  logic        wen_q;
  logic        err_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;

  logic        in_access;
  logic        done;
  logic        fail;
  logic        d_req;
  logic        grant_d;
  logic        grant_i;

  // Arbitration and completion/abort decisions for the current cycle.
  always_comb begin
    in_access = (state == DACC) || (state == IACC);
    done      = in_access && (bus.ramstate == RAM_ACCESS);
    fail      = in_access && !done && ((bus.ramstate == RAM_ERROR) || (cnt == LAST_CYCLE));
    d_req     = bus.dREN || bus.dWEN;
    // On a tie the side that was not served last wins; reset leaves fetch as last so data wins first.
    grant_d   = d_req && (!bus.iREN || (last_grant == SIDE_I));
    grant_i   = bus.iREN && !grant_d;
  end

  // Access FSM: latches the granted request and owns all registered outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= SIDE_I;
      cnt        <= 8'd0;
      addr_q     <= 32'd0;
      store_q    <= 32'd0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      iload_q    <= 32'd0;
      dload_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          cnt   <= 8'd0;
          if (grant_d) begin
            state   <= DACC;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            // A simultaneous read and write request is served as a write.
            ren_q   <= !bus.dWEN;
            wen_q   <= bus.dWEN;
          end else if (grant_i) begin
            state  <= IACC;
            addr_q <= bus.iaddr;
            ren_q  <= 1'b1;
            wen_q  <= 1'b0;
          end
        end
        DACC, IACC: begin
          if (done) begin
            state      <= IDLE;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            last_grant <= (state == IACC) ? SIDE_I : SIDE_D;
            if (ren_q && (state == IACC)) iload_q <= bus.ramload;
            if (ren_q && (state == DACC)) dload_q <= bus.ramload;
          end else if (fail) begin
            // Aborted access still counts as a turn so the other side is not starved.
            state      <= ABORT;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b1;
            last_grant <= (state == IACC) ? SIDE_I : SIDE_D;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ABORT: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ren_q <= 1'b0;
          wen_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  // Waits and loads bypass the registers only in the completion cycle.
  always_comb begin
    bus.iwait    = !(done && (state == IACC));
    bus.dwait    = !(done && (state == DACC));
    bus.iload    = (done && (state == IACC) && ren_q) ? bus.ramload : iload_q;
    bus.dload    = (done && (state == DACC) && ren_q) ? bus.ramload : dload_q;
    bus.ramREN   = ren_q;
    bus.ramWEN   = wen_q;
    bus.ramaddr  = addr_q;
    bus.ramstore = store_q;
    bus.err      = err_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed and randomized self-checking bench for memory_arbiter
module tb_memory_arbiter;

  localparam int unsigned TMO = 3;
  localparam logic [1:0] R_FREE = 2'b00;
  localparam logic [1:0] R_BUSY = 2'b01;
  localparam logic [1:0] R_ACC  = 2'b10;
  localparam logic [1:0] R_ERR  = 2'b11;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  memory_arbiter_if bus ();

  memory_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = R_FREE;
  endtask

  task automatic test_reset();
    nRST = 0;
    clear_inputs();
    tick();
    #1;
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN got=%0b exp=0", bus.ramREN); end
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN got=%0b exp=0", bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'd0) begin errors++; $display("FAIL reset_ramaddr got=%h exp=0", bus.ramaddr); end
    checks++; if (bus.ramstore !== 32'd0) begin errors++; $display("FAIL reset_ramstore got=%h exp=0", bus.ramstore); end
    checks++; if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin errors++; $display("FAIL reset_waits got=%0b%0b exp=11", bus.iwait, bus.dwait); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    checks++; if (bus.iload !== 32'd0 || bus.dload !== 32'd0) begin errors++; $display("FAIL reset_loads got=%h/%h exp=0/0", bus.iload, bus.dload); end
    nRST = 1;
  endtask

  // Both sides request continuously: expect D, idle, I, idle, D, idle, I.
  task automatic test_tie();
    logic [31:0] ld;
    logic side_i;
    bus.dREN = 1; bus.dWEN = 0; bus.iREN = 1;
    bus.daddr = 32'h500; bus.iaddr = 32'h600; bus.ramstate = R_ACC;
    tick();
    for (int k = 0; k < 8; k++) begin
      ld = 32'h1000 + k;
      bus.ramload = ld;
      if (k == 6) begin bus.dREN = 0; bus.iREN = 0; end
      #1;
      if (k % 2 == 0) begin
        side_i = ((k / 2) % 2) == 1;
        checks++; if (bus.ramaddr !== (side_i ? 32'h600 : 32'h500)) begin errors++; $display("FAIL tie_addr k=%0d got=%h exp=%h", k, bus.ramaddr, side_i ? 32'h600 : 32'h500); end
        checks++; if (bus.iwait !== !side_i || bus.dwait !== side_i) begin errors++; $display("FAIL tie_waits k=%0d got i=%0b d=%0b exp i=%0b d=%0b", k, bus.iwait, bus.dwait, !side_i, side_i); end
        checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL tie_ren k=%0d got=%0b exp=1", k, bus.ramREN); end
        checks++; if ((side_i ? bus.iload : bus.dload) !== ld) begin errors++; $display("FAIL tie_load k=%0d got=%h exp=%h", k, side_i ? bus.iload : bus.dload, ld); end
      end else begin
        checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin errors++; $display("FAIL tie_idle k=%0d got ren=%0b iw=%0b dw=%0b exp 0 1 1", k, bus.ramREN, bus.iwait, bus.dwait); end
      end
      tick();
    end
  endtask

  task automatic test_fetch();
    clear_inputs();
    bus.iREN = 1; bus.iaddr = 32'h40;
    #1;
    checks++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL fetch_idle got iw=%0b ren=%0b exp 1 0", bus.iwait, bus.ramREN); end
    tick();
    bus.iREN = 0;
    #1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 1'b1) begin errors++; $display("FAIL fetch_c1 got ren=%0b addr=%h iw=%0b exp 1 40 1", bus.ramREN, bus.ramaddr, bus.iwait); end
    tick();
    bus.ramstate = R_ACC; bus.ramload = 32'h2402_0005;
    #1;
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 1'b0) begin errors++; $display("FAIL fetch_c2 got ren=%0b addr=%h iw=%0b exp 1 40 0", bus.ramREN, bus.ramaddr, bus.iwait); end
    checks++; if (bus.iload !== 32'h2402_0005) begin errors++; $display("FAIL fetch_load got=%h exp=24020005", bus.iload); end
    tick();
    bus.ramstate = R_FREE; bus.ramload = 32'h1234_5678;
    #1;
    checks++; if (bus.iload !== 32'h2402_0005 || bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL fetch_hold got load=%h iw=%0b ren=%0b exp 24020005 1 0", bus.iload, bus.iwait, bus.ramREN); end
  endtask

  task automatic test_store();
    logic [31:0] dl;
    dl = bus.dload;
    clear_inputs();
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
    tick();
    bus.dREN = 0; bus.dWEN = 0; bus.ramstate = R_ACC; bus.ramload = 32'h5555_AAAA;
    #1;
    checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL store_strobes got wen=%0b ren=%0b exp 1 0", bus.ramWEN, bus.ramREN); end
    checks++; if (bus.ramstore !== 32'hDEAD_BEEF || bus.ramaddr !== 32'h100) begin errors++; $display("FAIL store_data got %h@%h exp deadbeef@100", bus.ramstore, bus.ramaddr); end
    checks++; if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin errors++; $display("FAIL store_wait got dw=%0b iw=%0b exp 0 1", bus.dwait, bus.iwait); end
    tick();
    bus.ramstate = R_FREE;
    #1;
    checks++; if (bus.dwait !== 1'b1 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL store_after got dw=%0b wen=%0b exp 1 0", bus.dwait, bus.ramWEN); end
    checks++; if (bus.dload !== dl) begin errors++; $display("FAIL store_dload got=%h exp=%h", bus.dload, dl); end
  endtask

  task automatic test_timeout();
    int err_seen;
    err_seen = 0;
    clear_inputs();
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = R_BUSY;
    tick();
    for (int c = 0; c < TMO; c++) begin
      #1;
      checks++; if (bus.ramREN !== 1'b1 || bus.dwait !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL timeout_acc c=%0d got ren=%0b dw=%0b err=%0b exp 1 1 0", c, bus.ramREN, bus.dwait, bus.err); end
      if (bus.err === 1'b1) err_seen++;
      if (c == TMO - 1) bus.dREN = 0;
      tick();
    end
    #1;
    checks++; if (bus.err !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL timeout_abort got err=%0b ren=%0b wen=%0b exp 1 0 0", bus.err, bus.ramREN, bus.ramWEN); end
    checks++; if (bus.dwait !== 1'b1 || bus.iwait !== 1'b1) begin errors++; $display("FAIL timeout_waits got dw=%0b iw=%0b exp 1 1", bus.dwait, bus.iwait); end
    if (bus.err === 1'b1) err_seen++;
    tick();
    checks++; if (bus.err !== 1'b0 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL timeout_after got err=%0b ren=%0b exp 0 0", bus.err, bus.ramREN); end
    if (bus.err === 1'b1) err_seen++;
    checks++; if (err_seen != 1) begin errors++; $display("FAIL timeout_err_count got=%0d exp=1", err_seen); end
  endtask

  task automatic test_reset_mid_read();
    clear_inputs();
    bus.dREN = 1; bus.daddr = 32'h700; bus.ramstate = R_BUSY;
    tick();
    #1;
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL rmr_c1 got ren=%0b exp 1", bus.ramREN); end
    tick();
    nRST = 0; bus.dREN = 0;
    tick();
    nRST = 1;
    #1;
    checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL rmr_after got ren=%0b iw=%0b dw=%0b err=%0b exp 0 1 1 0", bus.ramREN, bus.iwait, bus.dwait, bus.err); end
    checks++; if (bus.dload !== 32'd0 || bus.ramaddr !== 32'd0) begin errors++; $display("FAIL rmr_regs got dload=%h addr=%h exp 0 0", bus.dload, bus.ramaddr); end
  endtask

  // Straight after reset, so the tie also shows data winning the first arbitration.
  task automatic test_input_change();
    clear_inputs();
    bus.dREN = 1; bus.iREN = 1; bus.daddr = 32'h100; bus.iaddr = 32'h900; bus.ramstate = R_BUSY;
    tick();
    bus.daddr = 32'h200; bus.iaddr = 32'h904; bus.dWEN = 1;
    #1;
    checks++; if (bus.ramaddr !== 32'h100 || bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL chg_c1 got addr=%h ren=%0b wen=%0b exp 100 1 0", bus.ramaddr, bus.ramREN, bus.ramWEN); end
    tick();
    bus.daddr = 32'h204;
    #1;
    checks++; if (bus.ramaddr !== 32'h100) begin errors++; $display("FAIL chg_c2 got addr=%h exp 100", bus.ramaddr); end
    tick();
    bus.ramstate = R_ACC; bus.ramload = 32'hCAFE_F00D;
    bus.dREN = 0; bus.dWEN = 0; bus.iREN = 0;
    #1;
    checks++; if (bus.ramaddr !== 32'h100 || bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin errors++; $display("FAIL chg_done got addr=%h dw=%0b iw=%0b exp 100 0 1", bus.ramaddr, bus.dwait, bus.iwait); end
    checks++; if (bus.dload !== 32'hCAFE_F00D) begin errors++; $display("FAIL chg_dload got=%h exp cafef00d", bus.dload); end
    tick();
    bus.ramstate = R_FREE;
    #1;
    checks++; if (bus.dload !== 32'hCAFE_F00D || bus.ramREN !== 1'b0) begin errors++; $display("FAIL chg_hold got dload=%h ren=%0b exp cafef00d 0", bus.dload, bus.ramREN); end
  endtask

  // Transaction-level reference: at most one outstanding access, one idle or abort cycle between them.
  task automatic test_random();
    bit          m_active, m_abort, m_side_i, m_write, m_last_i;
    int          m_age;
    logic [31:0] m_addr, m_store, m_iload, m_dload;
    bit          comp, dreq;
    logic [31:0] e_iload, e_dload;
    int          r;
    nRST = 0;
    clear_inputs();
    tick();
    nRST = 1;
    m_active = 0; m_abort = 0; m_last_i = 1; m_age = 0;
    m_side_i = 0; m_write = 0; m_addr = 0; m_store = 0; m_iload = 0; m_dload = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 3) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 5) == 0) bus.dWEN = ~bus.dWEN;
      bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom; bus.ramload = $urandom;
      r = $urandom_range(0, 19);
      bus.ramstate = (r < 6) ? R_ACC : (r < 7) ? R_ERR : (r < 13) ? R_BUSY : R_FREE;
      #1;
      comp    = m_active && (bus.ramstate == R_ACC);
      e_iload = (comp && m_side_i) ? bus.ramload : m_iload;
      e_dload = (comp && !m_side_i && !m_write) ? bus.ramload : m_dload;
      checks++; if (bus.ramREN !== (m_active && !m_write) || bus.ramWEN !== (m_active && m_write)) begin errors++; $display("FAIL rnd_strobes cyc=%0d got ren=%0b wen=%0b exp %0b %0b", cyc, bus.ramREN, bus.ramWEN, m_active && !m_write, m_active && m_write); end
      checks++; if (bus.iwait !== !(comp && m_side_i) || bus.dwait !== !(comp && !m_side_i)) begin errors++; $display("FAIL rnd_waits cyc=%0d got iw=%0b dw=%0b exp %0b %0b", cyc, bus.iwait, bus.dwait, !(comp && m_side_i), !(comp && !m_side_i)); end
      checks++; if (bus.err !== m_abort) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, bus.err, m_abort); end
      checks++; if (bus.iload !== e_iload || bus.dload !== e_dload) begin errors++; $display("FAIL rnd_loads cyc=%0d got %h/%h exp %h/%h", cyc, bus.iload, bus.dload, e_iload, e_dload); end
      if (m_active) begin
        checks++; if (bus.ramaddr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.ramaddr, m_addr); end
        if (m_write) begin
          checks++; if (bus.ramstore !== m_store) begin errors++; $display("FAIL rnd_store cyc=%0d got=%h exp=%h", cyc, bus.ramstore, m_store); end
        end
      end
      m_iload = e_iload;
      m_dload = e_dload;
      if (m_abort) begin
        m_abort = 0;
      end else if (m_active) begin
        if (comp) begin
          m_active = 0; m_last_i = m_side_i;
        end else begin
          m_age++;
          if (bus.ramstate == R_ERR || m_age >= TMO) begin
            m_active = 0; m_abort = 1; m_last_i = m_side_i;
          end
        end
      end else begin
        dreq = bus.dREN || bus.dWEN;
        m_age = 0;
        if (dreq && (!bus.iREN || m_last_i)) begin
          m_active = 1; m_side_i = 0; m_write = bus.dWEN; m_addr = bus.daddr; m_store = bus.dstore;
        end else if (bus.iREN) begin
          m_active = 1; m_side_i = 1; m_write = 0; m_addr = bus.iaddr;
        end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 0;
    clear_inputs();
    test_reset();
    test_tie();
    test_fetch();
    test_store();
    test_timeout();
    test_reset_mid_read();
    test_input_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum cycles one RAM access may stay outstanding before it is aborted (legal range 1..255).
REQ-002 The block SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nRST, input, 1: reset, synchronous, active-low.
REQ-004 The block SHALL have port iREN, input, 1: instruction fetch request.
REQ-005 The block SHALL have port iaddr, input, 32: fetch address.
REQ-006 The block SHALL have port iload, output, 32: fetched instruction.
REQ-007 The block SHALL have port iwait, output, 1: low exactly in the fetch completion cycle.
REQ-008 The block SHALL have ports dREN and dWEN, input, 1 each: data read and data write requests.
REQ-009 The block SHALL have ports daddr and dstore, input, 32 each: data address and store data.
REQ-010 The block SHALL have port dload, output, 32: loaded data.
REQ-011 The block SHALL have port dwait, output, 1: low exactly in the data completion cycle.
REQ-012 The block SHALL have ports ramREN and ramWEN, output, 1 each: RAM read and write strobes.
REQ-013 The block SHALL have ports ramaddr and ramstore, output, 32 each: RAM address and write data.
REQ-014 The block SHALL have port ramload, input, 32: RAM read data.
REQ-015 The block SHALL have port ramstate, input, 2: RAM status, encoded FREE=00, BUSY=01, ACCESS=10, ERROR=11.
REQ-016 The block SHALL have port err, output, 1: one-cycle pulse when an access is aborted.

Function
REQ-017 The FSM SHALL have the states IDLE, DACC, IACC and ABORT.
REQ-018 Leaving IDLE:
- When a data request (dREN|dWEN) and iREN are both pending, the grant SHALL go to the side not granted last (a 1-bit last_grant register), so neither side starves.
- When only one side is pending, that side SHALL be granted.
- The grant SHALL move the FSM to DACC or IACC.
REQ-019 At the grant edge, the block SHALL latch address, store data and access type; the RAM outputs SHALL come only from these latched values until the FSM returns to IDLE, and input changes mid-access SHALL be ignored.
REQ-020 When dREN and dWEN are both high at grant, the access SHALL be a write.
REQ-021 During a read access ramREN=1 and ramWEN=0; during a write access ramWEN=1 and ramREN=0; in IDLE and ABORT both strobes SHALL be 0.
REQ-022 Completion SHALL occur in the DACC/IACC cycle where ramstate==ACCESS:
- The matching wait output SHALL go low combinationally in that cycle.
- For a read, the matching load output SHALL equal ramload in that cycle and SHALL be registered and held afterwards.
- The FSM SHALL return to IDLE at the next edge, and last_grant SHALL update.
REQ-023 Minimum latency SHALL be request at edge N, grant at N, completion cycle N+1 or later; there SHALL be no back-to-back completions, since one IDLE cycle always separates accesses.
REQ-024 An 8-bit cycle counter SHALL clear at grant and increment each DACC/IACC cycle. When it reaches TIMEOUT without completion, or when ramstate==ERROR, the FSM SHALL enter ABORT.
REQ-025 ABORT SHALL last one cycle:
- err=1.
- Both waits SHALL stay high and both strobes SHALL be 0.
- The next state SHALL be IDLE, and last_grant SHALL update as if the access had completed.
- The aborted request SHALL be re-arbitrated only if the requester still asserts it.
REQ-026 If a requester deasserts mid-access, the latched access SHALL still run to completion or abort.
REQ-027 iwait and dwait SHALL be 1 in every cycle other than their own completion cycle, including when the corresponding request is idle.
REQ-028 ramstate FREE and BUSY SHALL be treated identically (keep waiting).

Reset
REQ-029 When nRST=0 at a rising edge, the block SHALL load state IDLE, counter 0, last_grant=instruction (data wins the first tie), latched registers 0 and iload/dload 0.
REQ-030 Outputs in the cycle after reset SHALL be ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1 and err=0.
REQ-031 Reset asserted mid-access SHALL abandon the access with no completion pulse and no err pulse.

Verification
REQ-032 Fetch: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS on the 2nd cycle after grant with ramload=0x2402_0005 -> ramREN=1 and ramaddr=0x40 for 2 cycles, iwait=0 and iload=0x2402_0005 in the completion cycle, then iload held.
REQ-033 Tie: dREN and iREN asserted together continuously -> grant order D, I, D, I, with one IDLE cycle between accesses.
REQ-034 Store: dWEN=dREN=1, daddr=0x100, dstore=0xDEAD_BEEF, ramstate=ACCESS immediately -> ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF, dwait low for 1 cycle.
REQ-035 Timeout: TIMEOUT=3, ramstate held BUSY -> ABORT after 3 access cycles, err pulses once, dwait never low, strobes 0 in the ABORT cycle.
REQ-036 Reset mid-read: nRST=0 in the 2nd access cycle -> next cycle ramREN=0, waits=1, err=0, state IDLE, dload=0.
REQ-037 Input change: daddr changes from 0x100 to 0x200 mid-access -> ramaddr stays 0x100 until completion.
